// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter granting a fetch port and a data port
// single-transaction access to a combinational-read RAM.
`ifndef MEM_SIZE
`define MEM_SIZE 4096
`endif
`ifndef RAM_NOP
`define RAM_NOP 2'd0
`endif
`ifndef RAM_READ
`define RAM_READ 2'd1
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'd2
`endif
module ram_arbiter #(
  parameter int MEM_SIZE = `MEM_SIZE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_if_rready,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  input  logic        i_d_rready,
  output logic [1:0]  o_ram_do,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_val,
  input  logic [31:0] i_ram_val,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [31:0] MAX_ADDR = 32'(MEM_SIZE - 4);
  state_t      state, nxt;
  logic        rr_d, port_d, we_q, err_q, any_gnt, bad, rready_sel;
  logic [31:0] addr_q, wdata_q, rdata_q, sel_addr;
  // rr_d set means the data port wins the next contended cycle
  assign o_if_gnt   = i_rst_n && state == IDLE && i_if_req && (!i_d_req || !rr_d);
  assign o_d_gnt    = i_rst_n && state == IDLE && i_d_req && (!i_if_req || rr_d);
  assign any_gnt    = o_if_gnt || o_d_gnt;
  assign sel_addr   = o_d_gnt ? i_d_addr : i_if_addr;
  assign bad        = sel_addr[1:0] != 2'b00 || sel_addr > MAX_ADDR;
  assign rready_sel = port_d ? i_d_rready : i_if_rready;
  assign o_busy      = state != IDLE;
  assign o_if_rvalid = state == RESP && !port_d;
  assign o_d_rvalid  = state == RESP && port_d;
  assign o_if_rdata  = o_if_rvalid ? rdata_q : '0;
  assign o_d_rdata   = o_d_rvalid ? rdata_q : '0;
  assign o_if_err    = o_if_rvalid && err_q;
  assign o_d_err     = o_d_rvalid && err_q;
  assign o_ram_do    = (i_rst_n && state == ACCESS && !err_q) ? (we_q ? `RAM_WRITE : `RAM_READ) : `RAM_NOP;
  assign o_ram_addr  = addr_q;
  assign o_ram_val   = wdata_q;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (any_gnt ? ACCESS : IDLE) :
          state == ACCESS ? RESP :
          state == RESP ? (rready_sel ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      rr_d    <= 1'b1;
      port_d  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (any_gnt) begin
        rr_d    <= o_if_gnt;
        port_d  <= o_d_gnt;
        we_q    <= o_d_gnt && i_d_we;
        err_q   <= bad;
        addr_q  <= sel_addr;
        wdata_q <= o_d_gnt ? i_d_wdata : '0;
      end
      if (state == ACCESS) rdata_q <= (err_q || we_q) ? '0 : i_ram_val;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default `MEM_SIZE, RAM size in bytes; used for range checking.
REQ-002 i_clk  in  1  sole clock; all state updates on posedge.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_if_req  in  1  fetch port request (read-only).
REQ-005 i_if_addr  in  32  fetch byte address.
REQ-006 o_if_gnt  out  1  fetch request accepted this cycle.
REQ-007 o_if_rvalid / o_if_rdata / o_if_err  out  1/32/1  fetch response valid, data, error.
REQ-008 i_if_rready  in  1  fetch requester accepts response.
REQ-009 i_d_req, i_d_we  in  1,1  data port request; 1=write, 0=read.
REQ-010 i_d_addr, i_d_wdata  in  32,32  data byte address, write data.
REQ-011 o_d_gnt  out  1  data request accepted this cycle.
REQ-012 o_d_rvalid / o_d_rdata / o_d_err  out  1/32/1  data response valid, data (0 for writes), error.
REQ-013 i_d_rready  in  1  data requester accepts response.
REQ-014 o_ram_do  out  2  RAM op, `RAM_* encoding (NOP/READ/WRITE).
REQ-015 o_ram_addr, o_ram_val  out  32,32  RAM address, RAM write data.
REQ-016 i_ram_val  in  32  RAM combinational read data (big-endian word at o_ram_addr).
REQ-017 o_busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; one transaction in flight at most.
REQ-019 IDLE: o_*_gnt combinational; gnt asserted to at most one port, only when its req is high.
REQ-020 Arbitration: single requester wins; both requesting -> port not granted last wins (round-robin); pointer after reset favours D.
REQ-021 On grant: latch port id, op (fetch always read), addr, wdata; IDLE->ACCESS next edge.
REQ-022 Error check at grant: addr[1:0]!=0 or addr > MEM_SIZE-4 -> err flag latched, RAM op suppressed.
REQ-023 ACCESS (exactly 1 cycle): o_ram_do=READ/WRITE per latched op (NOP if err); o_ram_addr/o_ram_val from latches; read data captured from i_ram_val at end of cycle; ACCESS->RESP.
REQ-024 o_ram_do SHALL be NOP in IDLE and RESP, and NOP whenever i_rst_n is low (combinational gating; no write on reset edge).
REQ-025 RESP: rvalid high to granted port only; rdata/err stable until rready; rready high -> IDLE next edge.
REQ-026 Latency: gnt in cycle N -> RAM op in N+1 -> rvalid in N+2; minimum 3 cycles per transaction.
REQ-027 Errored response: err=1, rdata=0; errored write leaves RAM unchanged.
REQ-028 Write response: rdata=0, err=0 when valid.
REQ-029 Request held low/withdrawn in IDLE -> no grant, no state change; requests in ACCESS/RESP ignored (gnt low).
REQ-030 rready while rvalid low has no effect.
REQ-031 Round-robin pointer updates only on grant.

Reset
REQ-032 i_rst_n low at posedge: state=IDLE, gnt/rvalid/err=0, rdata=0, o_busy=0, latches=0, pointer favours D.
REQ-033 Reset in ACCESS or RESP drops transaction: no response issued, no RAM write performed.

Verification
REQ-034 D write 0x11223344 @0x10, then IF read @0x10 -> IF rdata=0x11223344 at gnt+2, err=0.
REQ-035 IF and D both request in IDLE after reset -> D granted first, IF next; repeated contention alternates grants.
REQ-036 D read @0x3 -> err=1, rdata=0, o_ram_do NOP in ACCESS; write @MEM_SIZE-2 -> err=1, RAM unchanged.
REQ-037 rready held low 5 cycles in RESP -> rvalid/rdata stable, gnt low despite pending req; rready=1 -> IDLE, next grant following cycle.
REQ-038 Reset asserted during write ACCESS -> o_ram_do=NOP that cycle, target word unchanged, no rvalid afterwards.
